bcd_decoder_stream: RTL
=======================

# bcd_decoder_stream

Streaming BCD-to-decimal decoder, the receive-side counterpart of the team's 10-line-to-BCD encoder. It accepts 4-bit BCD digits over a valid/ready handshake and decodes each to a 10-bit one-hot decimal line vector. Results are buffered in a small FIFO and presented on a second valid/ready handshake. Codes 10–15 are flagged as errors and counted. The block sits between a digit source (serial front end or encoder loopback) and display/decimal-select logic.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- CNT_W, 8: width of error and digit counters.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_bcd holds a digit.
- in_ready  out  1  block can accept a digit this cycle.
- in_bcd  in  4  BCD digit, 0–9 legal.
- out_valid  out  1  out_d/out_err hold a decoded entry.
- out_ready  in  1  consumer takes the entry this cycle.
- out_d  out  10  one-hot decimal; bit n set for digit n; all-zero on error.
- out_err  out  1  entry came from an illegal code (10–15).
- err_count  out  CNT_W  illegal codes accepted since reset; saturating.
- digit_count  out  CNT_W  legal digits accepted since reset; wraps modulo 2^CNT_W.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Decode on write: legal code k → entry {out_d = 1<<k, out_err = 0}. Illegal code → {out_d = 10'b0, out_err = 1}. Illegal entries are stored in order and never dropped.
- FIFO: DEPTH entries of 11 bits; read/write pointers are $clog2(DEPTH) bits wide and wrap naturally; occupancy counter 0..DEPTH.
- in_ready = (level != DEPTH). It is registered-state only, with no combinational path from out_ready. When full, in_ready = 0 even if out_ready = 1 in the same cycle.
- out_valid = (level != 0). out_d/out_err come from the read-pointer entry and stay stable while out_valid && !out_ready.
- Simultaneous push and pop at 0 < level < DEPTH: level unchanged, both pointers advance.
- Push at level 0 with out_ready = 1: no bypass. The entry appears on the next cycle.
- err_count increments on each accepted illegal code and holds at 2^CNT_W−1.
- digit_count increments on each accepted legal code and wraps to 0.
- Counters update on acceptance, not on output.
- in_bcd is ignored when in_valid = 0 or in_ready = 0.

## Timing
- Reset (asynchronous assert, synchronous release):
  - in_ready = 1, out_valid = 0, out_d = 0, out_err = 0.
  - err_count = 0, digit_count = 0, level = 0.
  - Pointers 0; FIFO contents don't-care but never visible.
- Latency: a digit accepted at edge N is visible on out_* after edge N (valid in cycle N+1) if the FIFO was empty.
- Throughput: one digit per cycle sustained when out_ready is held high.
- level, in_ready and out_valid all update on the same edge as the transfer.
- Reset mid-stream: all entries are discarded immediately and out_valid drops asynchronously. No partial entry survives.

## Test plan
- Reset then idle:
  - Required: in_ready = 1, out_valid = 0, out_d = 0, counters = 0, level = 0.
- Stream 0..9 back-to-back with out_ready = 1:
  - Required: out_d = 10'b0000000001, 10'b0000000010 … 10'b1000000000 in order, each one cycle after acceptance.
  - Required: out_err = 0 throughout; digit_count = 10; err_count = 0.
- Send 4'd12 between 3 and 7:
  - Required outputs in order: 10'b0000001000, then {0, out_err = 1}, then 10'b0010000000.
  - Required: err_count = 1, digit_count = 2.
- Backpressure (out_ready = 0, DEPTH = 4, send 5 digits 1, 2, 3, 4, 5):
  - Required: first 4 accepted; in_ready = 0 at level = 4; digit 5 held off; out_d stable at 10'b0000000010.
  - Then raise out_ready: entries drain in order 1, 2, 3, 4, 5.
  - Required: in_ready stays 0 during the full cycle even with out_ready = 1.
- Counter saturation and wrap (CNT_W = 4):
  - 17 illegal codes → err_count = 15.
  - 17 legal digits → digit_count = 1.
- Async reset asserted mid-stream with level = 3:
  - Required: out_valid = 0 and level = 0 before the next clk edge.
  - Required: counters cleared; first post-reset digit decodes correctly.

Source files
------------

// File: rtl/bcd_decoder_stream.sv
// bcd_decoder_stream: accepts 4-bit BCD digits on a valid/ready handshake,
// decodes each to a one-hot decimal line vector (or an error flag for codes
// 10-15), buffers the results in a small FIFO and presents them on a second
// valid/ready handshake. Counts legal digits (wrapping) and illegal codes
// (saturating) at acceptance time.
module bcd_decoder_stream #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [3:0]                 in_bcd,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [9:0]                 out_d,
   output logic                       out_err,
   output logic [CNT_W-1:0]           err_count,
   output logic [CNT_W-1:0]           digit_count,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   // FIFO entry layout: {err, one-hot[9:0]}
   logic [DEPTH-1:0][10:0] mem_q, mem_d;
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]       level_q, level_d;
   logic [CNT_W-1:0]       err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0]       dig_cnt_q, dig_cnt_d;

   logic        push, pop;
   logic        illegal;
   logic [9:0]  onehot;
   logic [10:0] head;

   // Handshake status derives from registered occupancy only, so in_ready
   // never depends combinationally on out_ready.
   always_comb begin
      in_ready  = (level_q != LVL_W'(DEPTH));
      out_valid = (level_q != '0);
      push      = in_valid && in_ready;
      pop       = out_valid && out_ready;
   end

   // Decode the incoming code; illegal codes yield an all-zero vector.
   always_comb begin
      illegal = (in_bcd > 4'd9);
      onehot  = '0;
      for (int n = 0; n < 10; n++) begin
         onehot[n] = (in_bcd == 4'(n));
      end
   end

   // Next-state for storage, pointers, occupancy and counters.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      err_cnt_d = err_cnt_q;
      dig_cnt_d = dig_cnt_q;
      if (push) begin
         mem_d[wr_ptr_q] = {illegal, onehot};
         wr_ptr_d        = wr_ptr_q + 1'b1;
         if (illegal) begin
            if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_d = err_cnt_q + 1'b1;
         end else begin
            dig_cnt_d = dig_cnt_q + 1'b1;
         end
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   // State registers; reset discards every entry at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         err_cnt_q <= '0;
         dig_cnt_q <= '0;
      end else begin
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         err_cnt_q <= err_cnt_d;
         dig_cnt_q <= dig_cnt_d;
      end
   end

   // Head entry is masked when empty so stale storage is never visible.
   always_comb begin
      head        = mem_q[rd_ptr_q];
      out_d       = out_valid ? head[9:0] : 10'b0;
      out_err     = out_valid ? head[10]  : 1'b0;
      err_count   = err_cnt_q;
      digit_count = dig_cnt_q;
      level       = level_q;
   end

endmodule
